// File: rtl/multi_channel_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// multi_channel_pulse_sequencer
//
// NUM_CH independent burst generators sharing one synchronous trigger. After a
// trigger, each enabled channel waits D cycles, then emits N pulses that are
// W cycles high and separated by G cycles low. Triggers that arrive while a
// channel is busy are queued (up to QUEUE_DEPTH). Triggers that arrive while
// the queue is full are dropped and set a sticky overflow flag.
//
// Ports:
//   clk          main clock
//   rst_n        asynchronous active-low reset
//   trigger_in   single-cycle trigger, synchronous to clk
//   ch_enable    per-channel enable; low flushes the channel to IDLE
//   cfg_ch       channel selected by a configuration write
//   cfg_delay    delay D (cycles)
//   cfg_width    pulse high width W (cycles, 0 treated as 1)
//   cfg_gap      low gap G between pulses (cycles, 0 treated as 1)
//   cfg_count    pulses per burst N (0 treated as 1)
//   cfg_wr       loads all four fields into the shadow registers of cfg_ch
//   ovf_clear    clears the matching sticky overflow bits
//   trigger_out  registered pulse outputs
//   busy         channel running a burst or holding queued triggers
//   seq_done     one-cycle pulse in the cycle after the last pulse falls
//   overflow     sticky: a trigger was dropped because the queue was full
// -----------------------------------------------------------------------------
module multi_channel_pulse_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int DELAY_BITS  = 32,
   parameter int COUNT_BITS  = 16,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  trigger_in,
   input  logic [NUM_CH-1:0]     ch_enable,
   input  logic [3:0]            cfg_ch,
   input  logic [DELAY_BITS-1:0] cfg_delay,
   input  logic [DELAY_BITS-1:0] cfg_width,
   input  logic [DELAY_BITS-1:0] cfg_gap,
   input  logic [COUNT_BITS-1:0] cfg_count,
   input  logic                  cfg_wr,
   input  logic [NUM_CH-1:0]     ovf_clear,
   output logic [NUM_CH-1:0]     trigger_out,
   output logic [NUM_CH-1:0]     busy,
   output logic [NUM_CH-1:0]     seq_done,
   output logic [NUM_CH-1:0]     overflow
);

   localparam int PEND_BITS = $clog2(QUEUE_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DELAY_BITS-1:0] sh_delay, sh_width, sh_gap;
      logic [COUNT_BITS-1:0] sh_count;
      logic [DELAY_BITS-1:0] act_width, act_gap, timer;
      logic [COUNT_BITS-1:0] remaining;
      logic [PEND_BITS-1:0]  pending;
      state_t                state;
      logic                  out_q, done_q, ovf_q;
      logic                  cfg_hit, drop;

      // cfg_ch values >= NUM_CH match no channel and are ignored.
      assign cfg_hit = cfg_wr && (cfg_ch == 4'(gi));
      assign drop    = trigger_in && ch_enable[gi] && (state != IDLE) &&
                       (pending == PEND_BITS'(QUEUE_DEPTH));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_delay <= '0;
            sh_width <= DELAY_BITS'(1);
            sh_gap   <= DELAY_BITS'(1);
            sh_count <= COUNT_BITS'(1);
         end else if (cfg_hit) begin
            sh_delay <= cfg_delay;
            sh_width <= cfg_width;
            sh_gap   <= cfg_gap;
            sh_count <= cfg_count;
         end
      end

      // Timer holds "cycles left minus one" in HIGH/GAP, and the remaining
      // delay in DELAY, so the terminal test is always timer == 0.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            act_width <= DELAY_BITS'(1);
            act_gap   <= DELAY_BITS'(1);
            remaining <= '0;
            pending   <= '0;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
         end else begin
            done_q <= 1'b0;
            // A drop and a clear on the same edge leave the flag set.
            ovf_q  <= (ovf_q & ~ovf_clear[gi]) | drop;
            if (!ch_enable[gi]) begin
               state   <= IDLE;
               out_q   <= 1'b0;
               pending <= '0;
            end else begin
               case (state)
                  IDLE: begin
                     if (trigger_in || (pending != '0)) begin
                        // Trigger plus backlog: consume one, queue one.
                        if (!trigger_in)
                           pending <= pending - PEND_BITS'(1);
                        timer     <= sh_delay;
                        act_width <= (sh_width == '0) ? DELAY_BITS'(1) : sh_width;
                        act_gap   <= (sh_gap == '0) ? DELAY_BITS'(1) : sh_gap;
                        remaining <= (sh_count == '0) ? COUNT_BITS'(1) : sh_count;
                        state     <= DELAY;
                     end
                  end
                  DELAY: begin
                     if (timer == '0) begin
                        state <= HIGH;
                        out_q <= 1'b1;
                        timer <= act_width - DELAY_BITS'(1);
                     end else begin
                        timer <= timer - DELAY_BITS'(1);
                     end
                  end
                  HIGH: begin
                     if (timer == '0) begin
                        out_q <= 1'b0;
                        if (remaining > COUNT_BITS'(1)) begin
                           state     <= GAP;
                           timer     <= act_gap - DELAY_BITS'(1);
                           remaining <= remaining - COUNT_BITS'(1);
                        end else begin
                           state  <= IDLE;
                           done_q <= 1'b1;
                        end
                     end else begin
                        timer <= timer - DELAY_BITS'(1);
                     end
                  end
                  GAP: begin
                     if (timer == '0) begin
                        state <= HIGH;
                        out_q <= 1'b1;
                        timer <= act_width - DELAY_BITS'(1);
                     end else begin
                        timer <= timer - DELAY_BITS'(1);
                     end
                  end
                  default: state <= IDLE;
               endcase
               // Triggers while running, including the edge that returns to
               // IDLE, go to the queue.
               if ((state != IDLE) && trigger_in &&
                   (pending != PEND_BITS'(QUEUE_DEPTH)))
                  pending <= pending + PEND_BITS'(1);
            end
         end
      end

      assign trigger_out[gi] = out_q;
      assign busy[gi]        = (state != IDLE) || (pending != '0);
      assign seq_done[gi]    = done_q;
      assign overflow[gi]    = ovf_q;
   end

endmodule

// File: tb/tb_multi_channel_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for multi_channel_pulse_sequencer. A burst-level model predicts every
// output from the burst start edge and its parameters; a compare process
// checks all outputs at each falling edge, and directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_multi_channel_pulse_sequencer;
   localparam int NCH = 4;
   localparam int DB  = 8;
   localparam int CB  = 8;
   localparam int QD  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trigger_in = 1'b0;
   logic [NCH-1:0] ch_enable = '0;
   logic [3:0]    cfg_ch = '0;
   logic [DB-1:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
   logic [CB-1:0] cfg_count = '0;
   logic          cfg_wr = 1'b0;
   logic [NCH-1:0] ovf_clear = '0;
   logic [NCH-1:0] trigger_out, busy, seq_done, overflow;

   int tests = 0;
   int fails = 0;
   bit chk_on = 0;

   multi_channel_pulse_sequencer #(
      .NUM_CH(NCH), .DELAY_BITS(DB), .COUNT_BITS(CB), .QUEUE_DEPTH(QD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .trigger_in(trigger_in), .ch_enable(ch_enable),
      .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
      .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_wr(cfg_wr),
      .ovf_clear(ovf_clear), .trigger_out(trigger_out), .busy(busy),
      .seq_done(seq_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- burst-level model ----------------
   longint n = 0;
   longint m_start[NCH], m_d[NCH], m_w[NCH], m_g[NCH], m_n[NCH];
   int     m_pend[NCH];
   bit     m_act[NCH], m_ovf[NCH];
   longint sh_d[NCH], sh_w[NCH], sh_g[NCH], sh_n[NCH];
   logic [NCH-1:0] e_out = '0, e_busy = '0, e_done = '0, e_ovf = '0;

   function automatic longint burst_end(input int c);
      return m_start[c] + 1 + m_d[c] + m_n[c] * m_w[c] + (m_n[c] - 1) * m_g[c];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_act[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
            sh_d[c] = 0; sh_w[c] = 1; sh_g[c] = 1; sh_n[c] = 1;
            m_start[c] = 0; m_d[c] = 0; m_w[c] = 1; m_g[c] = 1; m_n[c] = 1;
         end
         e_out = '0; e_busy = '0; e_done = '0; e_ovf = '0;
      end else begin
         n = n + 1;
         for (int c = 0; c < NCH; c++) begin
            bit set, idle;
            longint r, endv;
            set  = 0;
            idle = !m_act[c] || (n > burst_end(c));
            if (!ch_enable[c]) begin
               m_act[c]  = 0;
               m_pend[c] = 0;
            end else if (idle) begin
               if (trigger_in || m_pend[c] > 0) begin
                  if (!trigger_in) m_pend[c]--;
                  m_act[c]   = 1;
                  m_start[c] = n;
                  m_d[c] = sh_d[c];
                  m_w[c] = (sh_w[c] == 0) ? 1 : sh_w[c];
                  m_g[c] = (sh_g[c] == 0) ? 1 : sh_g[c];
                  m_n[c] = (sh_n[c] == 0) ? 1 : sh_n[c];
               end
            end else if (trigger_in) begin
               if (m_pend[c] < QD) m_pend[c]++;
               else set = 1;
            end
            m_ovf[c] = (m_ovf[c] && !ovf_clear[c]) || set;
            if (cfg_wr && cfg_ch == c) begin
               sh_d[c] = cfg_delay; sh_w[c] = cfg_width;
               sh_g[c] = cfg_gap;   sh_n[c] = cfg_count;
            end
            endv = burst_end(c);
            r    = n - (m_start[c] + 1 + m_d[c]);
            e_out[c]  = m_act[c] && r >= 0 && r < m_n[c] * (m_w[c] + m_g[c]) &&
                        (r % (m_w[c] + m_g[c])) < m_w[c];
            e_done[c] = m_act[c] && n == endv;
            e_busy[c] = (m_act[c] && n < endv) || m_pend[c] > 0;
            e_ovf[c]  = m_ovf[c];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("model trigger_out", trigger_out, e_out);
         chk("model busy", busy, e_busy);
         chk("model seq_done", seq_done, e_done);
         chk("model overflow", overflow, e_ovf);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic cfg(input int ch, input int d, input int w, input int g, input int cnt);
      cfg_ch = 4'(ch); cfg_delay = DB'(d); cfg_width = DB'(w);
      cfg_gap = DB'(g); cfg_count = CB'(cnt); cfg_wr = 1'b1;
      step(1);
      cfg_wr = 1'b0;
   endtask

   task automatic trig();
      trigger_in = 1'b1;
      step(1);
      trigger_in = 1'b0;
   endtask

   initial begin
      int cnt;
      #3 chk_on = 1;
      step(2);
      chk("reset trigger_out", trigger_out, 0);
      chk("reset busy", busy, 0);
      chk("reset seq_done", seq_done, 0);
      chk("reset overflow", overflow, 0);
      rst_n = 1'b1;
      step(2);

      // Default single pulse, then a trigger on the falling edge is queued.
      $display("[TB] ch0 default pulse + trigger on fall edge");
      ch_enable = 4'b0001;
      trig();
      step(1); chk("ch0 rise t+1", trigger_out[0], 1);
      trigger_in = 1'b1; step(1); trigger_in = 1'b0;
      chk("ch0 fall t+2", trigger_out[0], 0);
      chk("ch0 done t+2", seq_done[0], 1);
      chk("ch0 queued busy t+2", busy[0], 1);
      step(1); chk("ch0 low t+3", trigger_out[0], 0);
      step(1); chk("ch0 queued rise t+4", trigger_out[0], 1);
      step(2); chk("ch0 idle t+6", busy[0], 0);

      // Burst D=5 W=3 G=2 N=3.
      $display("[TB] ch1 burst D=5 W=3 G=2 N=3");
      ch_enable = 4'b0010;
      cfg(1, 5, 3, 2, 3);
      trig();
      for (int k = 1; k <= 20; k++) begin
         step(1);
         chk($sformatf("ch1 out k=%0d", k), trigger_out[1],
             (k inside {6, 7, 8, 11, 12, 13, 16, 17, 18}) ? 1 : 0);
         chk($sformatf("ch1 done k=%0d", k), seq_done[1], (k == 19) ? 1 : 0);
      end
      chk("ch1 busy after burst", busy[1], 0);

      // Queue fill, overflow, clear priority.
      $display("[TB] ch2 queue/overflow");
      ch_enable = 4'b0100;
      cfg(2, 4, 2, 1, 1);
      trigger_in = 1'b1;
      step(6);
      chk("ch2 overflow set", overflow[2], 1);
      ovf_clear = 4'b0100;
      step(1);
      chk("ch2 drop beats clear", overflow[2], 1);
      trigger_in = 1'b0;
      step(1);
      chk("ch2 overflow cleared", overflow[2], 0);
      ovf_clear = '0;
      cnt = int'(seq_done[2]);
      for (int k = 0; k < 40; k++) begin
         step(1);
         cnt += int'(seq_done[2]);
      end
      chk("ch2 bursts emitted", cnt, 5);
      chk("ch2 busy drained", busy[2], 0);

      // Shadow/active separation.
      $display("[TB] ch0 config during burst");
      ch_enable = 4'b0001;
      cfg(0, 3, 1, 1, 1);
      trig();
      cfg(0, 10, 1, 1, 1);
      step(2); chk("ch0 old D t+3", trigger_out[0], 0);
      step(1); chk("ch0 old D t+4", trigger_out[0], 1);
      step(3);
      cfg_ch = 4'd0; cfg_delay = DB'(2); cfg_wr = 1'b1; trigger_in = 1'b1;
      step(1);
      cfg_wr = 1'b0; trigger_in = 1'b0;
      step(10); chk("ch0 D=10 t+10", trigger_out[0], 0);
      step(1);  chk("ch0 D=10 t+11", trigger_out[0], 1);
      step(3);
      cfg(4, 50, 1, 1, 1);
      trig();
      step(2); chk("ch0 D=2 t+2", trigger_out[0], 0);
      step(1); chk("ch0 D=2 t+3", trigger_out[0], 1);
      step(3);

      // Disable mid-HIGH with backlog.
      $display("[TB] ch1 disable mid-burst");
      ch_enable = 4'b0010;
      trigger_in = 1'b1; step(3); trigger_in = 1'b0;
      step(5);
      chk("ch1 high before disable", trigger_out[1], 1);
      chk("ch1 busy before disable", busy[1], 1);
      ch_enable = 4'b0000;
      step(1);
      chk("ch1 out after disable", trigger_out[1], 0);
      chk("ch1 busy after disable", busy[1], 0);
      chk("ch1 no done on disable", seq_done[1], 0);
      ch_enable = 4'b0010;
      trig();
      step(5); chk("ch1 re-enable t+5", trigger_out[1], 0);
      step(1); chk("ch1 re-enable t+6", trigger_out[1], 1);
      step(14);

      // Field boundaries: maximum delay and zero substitution.
      $display("[TB] ch3 boundaries");
      ch_enable = 4'b1000;
      cfg(3, 255, 0, 0, 0);
      trig();
      step(255); chk("ch3 Dmax t+255", trigger_out[3], 0);
      step(1);   chk("ch3 Dmax t+256", trigger_out[3], 1);
      step(1);   chk("ch3 W0 fall", trigger_out[3], 0);
      chk("ch3 N0 done", seq_done[3], 1);
      cfg(3, 0, 2, 0, 2);
      trig();
      step(3); chk("ch3 G0 gap", trigger_out[3], 0);
      step(1); chk("ch3 G0 second rise", trigger_out[3], 1);
      step(3);

      // Asynchronous reset mid-GAP.
      $display("[TB] async reset mid-gap");
      ch_enable = 4'b0010;
      cfg(1, 5, 3, 2, 3);
      trig();
      step(10);
      chk("ch1 busy in gap", busy[1], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst trigger_out", trigger_out, 0);
      chk("async rst busy", busy, 0);
      chk("async rst seq_done", seq_done, 0);
      @(negedge clk) rst_n = 1'b1;
      trig();
      step(1); chk("post-reset default rise", trigger_out[1], 1);
      step(1); chk("post-reset default fall", trigger_out[1], 0);
      chk("post-reset default done", seq_done[1], 1);
      step(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
